// File: rtl/manchester_serializer.sv
// Serializes one 16-chip Manchester word MSB-first, each chip held DIV clocks.
// Define MANCH_TX_PREAMBLE_EN to prefix every frame with 8 chips of 1,0,1,0,...
module manchester_serializer #(
    parameter int   DIV        = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        tx_out,
    output logic        tx_active,
    output logic        frame_done
);

    localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);

`ifdef MANCH_TX_PREAMBLE_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_SHIFT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd2
    } state_t;
`endif

    state_t          state, state_nx;
    logic [DW-1:0]   div_cnt, div_nx;
    logic [3:0]      chip_cnt, chip_nx;
    logic [15:0]     shreg, shreg_nx;
    logic            tx_r, tx_nx;
    logic            act_r, act_nx;

    logic            chip_end;
    logic            frame_last;
    logic            take;

    // Handshake: a word moves on a rising edge where word_valid and
    // word_ready are both high; word_ready depends only on registered state.
    assign chip_end   = (div_cnt == DIV_LAST);
    assign frame_last = (state == S_SHIFT) && chip_end && (chip_cnt == 4'd15);
    assign word_ready = (state == S_IDLE) || frame_last;
    assign frame_done = frame_last;
    assign take       = word_valid && word_ready;

    assign tx_out    = tx_r;
    assign tx_active = act_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            chip_cnt <= '0;
            shreg    <= '0;
            tx_r     <= IDLE_LEVEL;
            act_r    <= 1'b0;
        end else begin
            state    <= state_nx;
            div_cnt  <= div_nx;
            chip_cnt <= chip_nx;
            shreg    <= shreg_nx;
            tx_r     <= tx_nx;
            act_r    <= act_nx;
        end
    end

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        chip_nx  = chip_cnt;
        shreg_nx = shreg;
        tx_nx    = tx_r;
        act_nx   = act_r;

        if (take) begin
            // Load path is shared by IDLE and the last clock of a frame.
            div_nx  = '0;
            chip_nx = '0;
            act_nx  = 1'b1;
`ifdef MANCH_TX_PREAMBLE_EN
            state_nx = S_PRE;
            shreg_nx = word_in;
            tx_nx    = 1'b1;
`else
            state_nx = S_SHIFT;
            shreg_nx = {word_in[14:0], 1'b0};
            tx_nx    = word_in[15];
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx_nx  = IDLE_LEVEL;
                    act_nx = 1'b0;
                end
`ifdef MANCH_TX_PREAMBLE_EN
                S_PRE: begin
                    div_nx = chip_end ? '0 : div_cnt + DW'(1);
                    if (chip_end) begin
                        if (chip_cnt == 4'd7) begin
                            state_nx = S_SHIFT;
                            chip_nx  = '0;
                            tx_nx    = shreg[15];
                            shreg_nx = {shreg[14:0], 1'b0};
                        end else begin
                            // Preamble chip j is ~j[0]; the next chip is chip_cnt+1.
                            chip_nx = chip_cnt + 4'd1;
                            tx_nx   = chip_cnt[0];
                        end
                    end
                end
`endif
                S_SHIFT: begin
                    div_nx = chip_end ? '0 : div_cnt + DW'(1);
                    if (chip_end) begin
                        if (chip_cnt == 4'd15) begin
                            state_nx = S_IDLE;
                            chip_nx  = '0;
                            tx_nx    = IDLE_LEVEL;
                            act_nx   = 1'b0;
                        end else begin
                            chip_nx  = chip_cnt + 4'd1;
                            tx_nx    = shreg[15];
                            shreg_nx = {shreg[14:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    div_nx   = '0;
                    chip_nx  = '0;
                    tx_nx    = IDLE_LEVEL;
                    act_nx   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_serializer.sv
// Bench for manchester_serializer: DIV=4/IDLE=0 and DIV=1/IDLE=1 instances,
// chip-level scoreboard per instance, optional MANCH_TX_PREAMBLE_EN build.
module tb_manchester_serializer;

    localparam int DIV_A = 4;
    localparam int DIV_B = 1;
`ifdef MANCH_TX_PREAMBLE_EN
    localparam int PRE_CHIPS = 8;
`else
    localparam int PRE_CHIPS = 0;
`endif
    localparam int FL_A = (16 + PRE_CHIPS) * DIV_A;
    localparam int FL_B = (16 + PRE_CHIPS) * DIV_B;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [15:0] word_in_a, word_in_b;
    logic        word_valid_a, word_valid_b;
    logic        word_ready_a, word_ready_b;
    logic        tx_out_a, tx_out_b;
    logic        tx_active_a, tx_active_b;
    logic        frame_done_a, frame_done_b;

    logic [0:0]  exp_a_q[$];
    logic [0:0]  exp_b_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    manchester_serializer #(.DIV(DIV_A), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_a), .word_in(word_in_a), .word_valid(word_valid_a),
        .word_ready(word_ready_a), .tx_out(tx_out_a), .tx_active(tx_active_a),
        .frame_done(frame_done_a)
    );

    manchester_serializer #(.DIV(DIV_B), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_b), .word_in(word_in_b), .word_valid(word_valid_b),
        .word_ready(word_ready_b), .tx_out(tx_out_b), .tx_active(tx_active_b),
        .frame_done(frame_done_b)
    );

    // Expected line values, one entry per clock of the frame.
    task automatic push_frame_a(input logic [15:0] w);
        for (int p = 0; p < PRE_CHIPS; p++)
            for (int r = 0; r < DIV_A; r++) exp_a_q.push_back((p % 2) == 0);
        for (int k = 15; k >= 0; k--)
            for (int r = 0; r < DIV_A; r++) exp_a_q.push_back(w[k]);
    endtask

    task automatic push_frame_b(input logic [15:0] w);
        for (int p = 0; p < PRE_CHIPS; p++)
            for (int r = 0; r < DIV_B; r++) exp_b_q.push_back((p % 2) == 0);
        for (int k = 15; k >= 0; k--)
            for (int r = 0; r < DIV_B; r++) exp_b_q.push_back(w[k]);
    endtask

    // Walks one DUT-A frame from cycle T+1 to T+FL_A, sampling on negedges.
    task automatic check_frame_a(input string nm, input bit keep_valid,
                                 input int von_at, input logic [15:0] von_w,
                                 input int chg_at, input logic [15:0] chg_w);
        logic [0:0] e;
        for (int n = 1; n <= FL_A; n++) begin
            @(negedge clk);
            n_checks++;
            if (exp_a_q.size() == 0) begin
                n_errors++;
                $display("FAIL %s no expected chip at T+%0d", nm, n);
            end else begin
                e = exp_a_q.pop_front();
                if (tx_out_a !== e) begin
                    n_errors++;
                    $display("FAIL %s tx_out at T+%0d: got %b want %b", nm, n, tx_out_a, e);
                end
            end
            n_checks++;
            if (tx_active_a !== 1'b1) begin
                n_errors++;
                $display("FAIL %s tx_active at T+%0d: got %b want 1", nm, n, tx_active_a);
            end
            n_checks++;
            if (frame_done_a !== (n == FL_A)) begin
                n_errors++;
                $display("FAIL %s frame_done at T+%0d: got %b want %b", nm, n, frame_done_a, n == FL_A);
            end
            n_checks++;
            if (word_ready_a !== (n == FL_A)) begin
                n_errors++;
                $display("FAIL %s word_ready at T+%0d: got %b want %b", nm, n, word_ready_a, n == FL_A);
            end
            if (n == 1 && !keep_valid) word_valid_a = 1'b0;
            if (n == von_at) begin
                word_valid_a = 1'b1;
                word_in_a    = von_w;
            end
            if (n == chg_at) word_in_a = chg_w;
        end
    endtask

    task automatic test_reset;
        rst_a = 1'b0; rst_b = 1'b0;
        word_valid_a = 1'b0; word_valid_b = 1'b0;
        word_in_a = '0; word_in_b = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx_out_a, tx_active_a, frame_done_a, word_ready_a} !== 4'b0001) begin
            n_errors++;
            $display("FAIL reset_a {tx,act,done,rdy}: got %b want 0001",
                     {tx_out_a, tx_active_a, frame_done_a, word_ready_a});
        end
        n_checks++;
        if ({tx_out_b, tx_active_b, frame_done_b, word_ready_b} !== 4'b1001) begin
            n_errors++;
            $display("FAIL reset_b {tx,act,done,rdy}: got %b want 1001",
                     {tx_out_b, tx_active_b, frame_done_b, word_ready_b});
        end
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_a(input string nm, input logic [15:0] w);
        word_in_a = w;
        word_valid_a = 1'b1;
        n_checks++;
        if (word_ready_a !== 1'b1) begin
            n_errors++;
            $display("FAIL %s word_ready at T: got %b want 1", nm, word_ready_a);
        end
    endtask

    task automatic idle_check_a(input string nm);
        @(negedge clk);
        n_checks++;
        if ({tx_out_a, tx_active_a, frame_done_a, word_ready_a} !== 4'b0001) begin
            n_errors++;
            $display("FAIL %s idle {tx,act,done,rdy}: got %b want 0001", nm,
                     {tx_out_a, tx_active_a, frame_done_a, word_ready_a});
        end
    endtask

    task automatic test_single;
        start_a("single", 16'h9A56);
        push_frame_a(16'h9A56);
        check_frame_a("single", 1'b0, 0, 16'h0, 0, 16'h0);
        idle_check_a("single_after");
    endtask

    task automatic test_back_to_back;
        start_a("b2b", 16'hAAAA);
        push_frame_a(16'hAAAA);
        push_frame_a(16'h5555);
        check_frame_a("b2b_first", 1'b1, 0, 16'h0, 1, 16'h5555);
        check_frame_a("b2b_second", 1'b0, 0, 16'h0, 0, 16'h0);
        idle_check_a("b2b_after");
    endtask

    task automatic test_backpressure;
        start_a("bp", 16'hC3A5);
        push_frame_a(16'hC3A5);
        push_frame_a(16'hF0F0);
        check_frame_a("bp_first", 1'b0, 10, 16'h1234, 30, 16'hF0F0);
        check_frame_a("bp_second", 1'b0, 0, 16'h0, 0, 16'h0);
        idle_check_a("bp_after");
    endtask

    task automatic test_reset_mid_frame;
        logic [0:0] e;
        start_a("rst_mid", 16'h3C69);
        push_frame_a(16'h3C69);
        for (int n = 1; n < 20; n++) begin
            @(negedge clk);
            if (n == 1) word_valid_a = 1'b0;
            e = exp_a_q.pop_front();
            n_checks++;
            if (tx_out_a !== e || tx_active_a !== 1'b1) begin
                n_errors++;
                $display("FAIL rst_mid pre-reset T+%0d {tx,act}: got %b%b want %b1",
                         n, tx_out_a, tx_active_a, e);
            end
        end
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        n_checks++;
        if ({tx_out_a, tx_active_a, frame_done_a, word_ready_a} !== 4'b0001) begin
            n_errors++;
            $display("FAIL rst_mid in reset {tx,act,done,rdy}: got %b want 0001",
                     {tx_out_a, tx_active_a, frame_done_a, word_ready_a});
        end
        exp_a_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (frame_done_a !== 1'b0 || tx_active_a !== 1'b0) begin
                n_errors++;
                $display("FAIL rst_mid held {done,act}: got %b%b want 00", frame_done_a, tx_active_a);
            end
        end
        rst_a = 1'b1;
        idle_check_a("rst_mid_release");
        start_a("rst_mid_after", 16'h9A56);
        push_frame_a(16'h9A56);
        check_frame_a("rst_mid_after", 1'b0, 0, 16'h0, 0, 16'h0);
        idle_check_a("rst_mid_idle");
    endtask

    task automatic test_random;
        logic [15:0] w;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) idle_check_a("rand_gap");
            w = 16'($urandom_range(0, 16'hFFFF));
            start_a("rand", w);
            push_frame_a(w);
            check_frame_a("rand", 1'b0, 0, 16'h0, 0, 16'h0);
        end
        idle_check_a("rand_after");
    endtask

    task automatic test_div1;
        logic [0:0] e;
        word_in_b = 16'h00FF;
        word_valid_b = 1'b1;
        push_frame_b(16'h00FF);
        n_checks++;
        if (word_ready_b !== 1'b1) begin
            n_errors++;
            $display("FAIL div1 word_ready at T: got %b want 1", word_ready_b);
        end
        for (int n = 1; n <= FL_B; n++) begin
            @(negedge clk);
            if (n == 1) word_valid_b = 1'b0;
            e = exp_b_q.pop_front();
            n_checks++;
            if (tx_out_b !== e || tx_active_b !== 1'b1) begin
                n_errors++;
                $display("FAIL div1 T+%0d {tx,act}: got %b%b want %b1", n, tx_out_b, tx_active_b, e);
            end
            n_checks++;
            if (frame_done_b !== (n == FL_B)) begin
                n_errors++;
                $display("FAIL div1 frame_done at T+%0d: got %b want %b", n, frame_done_b, n == FL_B);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx_out_b, tx_active_b, frame_done_b, word_ready_b} !== 4'b1001) begin
                n_errors++;
                $display("FAIL div1 idle {tx,act,done,rdy}: got %b want 1001",
                         {tx_out_b, tx_active_b, frame_done_b, word_ready_b});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_random();
        test_div1();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
